// File: rtl/l2_output_encoder.sv
// ---------------------------------------------------------------------------
// l2_output_encoder
//
// Buffers single-cycle send pulses from the L2 controller datapath into three
// independent per-channel FIFOs and presents them on the outgoing valid/ready
// interfaces:
//   request-out  -> NoC   (l2_req_out_*_int)
//   response-out -> NoC   (l2_rsp_out_*_int)
//   read-response -> CPU  (l2_rd_rsp_*_int)
// Also produces a registered stall for decode_en gating, a drain indication
// for fence/drain handling, and a sticky overflow error.
//
// Optional feature macro: L2_OUT_BYPASS_EN
//   defined   : an empty channel forwards a send pulse combinationally to its
//               valid/data outputs in the same cycle; if the consumer is
//               ready the FIFO is not written.
//   undefined : fully registered outputs, one cycle push-to-valid latency.
//
// Parameters:
//   DEPTH  entries per channel FIFO (power of two, >= 2)
//   REQ_W  request-out payload width
//   RSP_W  response-out payload width
//   RD_W   read-response payload width
//
// Ports:
//   clk, rst                         clock (rising edge), async active-low reset
//   send_req_out / req_out_payload   push pulse + payload, request-out
//   send_rsp_out / rsp_out_payload   push pulse + payload, response-out
//   send_rd_rsp  / rd_rsp_payload    push pulse + payload, read-response
//   l2_req_out_{valid,ready,data}_int  request-out handshake
//   l2_rsp_out_{valid,ready,data}_int  response-out handshake
//   l2_rd_rsp_{valid,ready,data}_int   read-response handshake
//   out_stall     registered; high when any channel is at or near full
//   drain_req     level; fence/drain wants output quiescence
//   out_drained   drain_req with all channels empty and nothing arriving
//   overflow_err  sticky; a push was dropped on a full FIFO
// ---------------------------------------------------------------------------

// One output channel: circular FIFO with optional empty-bypass.
module l2_out_chan #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     ready,
    output logic                     valid,
    output logic [W-1:0]             data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt,
    output logic                     ovf_hit,
    output logic                     bypass_xfer
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_valid;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          bypass_sel;

    assign fifo_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign pop        = fifo_valid & ready;

`ifdef L2_OUT_BYPASS_EN
    assign bypass_sel = push & ~fifo_valid;
`else
    assign bypass_sel = 1'b0;
`endif

    assign bypass_xfer = bypass_sel & ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en   = push & ~bypass_xfer & (~full | pop);
    assign ovf_hit = push & full & ~pop;

    assign valid = fifo_valid | bypass_sel;
    assign data  = bypass_sel ? din : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({wr_en, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage is cleared on reset so data outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

module l2_output_encoder #(
    parameter int DEPTH = 2,
    parameter int REQ_W = 64,
    parameter int RSP_W = 64,
    parameter int RD_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_req_out,
    input  logic [REQ_W-1:0] req_out_payload,
    input  logic             send_rsp_out,
    input  logic [RSP_W-1:0] rsp_out_payload,
    input  logic             send_rd_rsp,
    input  logic [RD_W-1:0]  rd_rsp_payload,
    output logic             l2_req_out_valid_int,
    input  logic             l2_req_out_ready_int,
    output logic [REQ_W-1:0] l2_req_out_data_int,
    output logic             l2_rsp_out_valid_int,
    input  logic             l2_rsp_out_ready_int,
    output logic [RSP_W-1:0] l2_rsp_out_data_int,
    output logic             l2_rd_rsp_valid_int,
    input  logic             l2_rd_rsp_ready_int,
    output logic [RD_W-1:0]  l2_rd_rsp_data_int,
    output logic             out_stall,
    input  logic             drain_req,
    output logic             out_drained,
    output logic             overflow_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] req_cnt, req_cnt_nxt;
    logic [CW-1:0] rsp_cnt, rsp_cnt_nxt;
    logic [CW-1:0] rd_cnt,  rd_cnt_nxt;
    logic          req_ovf, rsp_ovf, rd_ovf;
    logic          req_byp, rsp_byp, rd_byp;
    logic          stall_nxt;

    l2_out_chan #(.DEPTH(DEPTH), .W(REQ_W)) u_req_chan (
        .clk         (clk),
        .rst         (rst),
        .push        (send_req_out),
        .din         (req_out_payload),
        .ready       (l2_req_out_ready_int),
        .valid       (l2_req_out_valid_int),
        .data        (l2_req_out_data_int),
        .count       (req_cnt),
        .count_nxt   (req_cnt_nxt),
        .ovf_hit     (req_ovf),
        .bypass_xfer (req_byp)
    );

    l2_out_chan #(.DEPTH(DEPTH), .W(RSP_W)) u_rsp_chan (
        .clk         (clk),
        .rst         (rst),
        .push        (send_rsp_out),
        .din         (rsp_out_payload),
        .ready       (l2_rsp_out_ready_int),
        .valid       (l2_rsp_out_valid_int),
        .data        (l2_rsp_out_data_int),
        .count       (rsp_cnt),
        .count_nxt   (rsp_cnt_nxt),
        .ovf_hit     (rsp_ovf),
        .bypass_xfer (rsp_byp)
    );

    l2_out_chan #(.DEPTH(DEPTH), .W(RD_W)) u_rd_chan (
        .clk         (clk),
        .rst         (rst),
        .push        (send_rd_rsp),
        .din         (rd_rsp_payload),
        .ready       (l2_rd_rsp_ready_int),
        .valid       (l2_rd_rsp_valid_int),
        .data        (l2_rd_rsp_data_int),
        .count       (rd_cnt),
        .count_nxt   (rd_cnt_nxt),
        .ovf_hit     (rd_ovf),
        .bypass_xfer (rd_byp)
    );

    // Stall one entry early: the decoder has one push already in flight
    // behind its registered stage when it sees out_stall.
    assign stall_nxt = (req_cnt_nxt >= CW'(DEPTH - 1)) |
                       (rsp_cnt_nxt >= CW'(DEPTH - 1)) |
                       (rd_cnt_nxt  >= CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_stall    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            out_stall <= stall_nxt;
            if (req_ovf | rsp_ovf | rd_ovf) overflow_err <= 1'b1;
        end
    end

    assign out_drained = drain_req &
                         (req_cnt == '0) & (rsp_cnt == '0) & (rd_cnt == '0) &
                         ~(send_req_out | send_rsp_out | send_rd_rsp) &
                         ~(req_byp | rsp_byp | rd_byp);
endmodule
